// File: rtl/tp_pkg.sv
// Shared types and constants for the tiny-processor serial load path.
package tp_pkg;

   localparam int unsigned DATA_W  = 8;
   localparam int unsigned ADDR_W  = 4;
   localparam int unsigned FRAME_W = DATA_W + ADDR_W;
   localparam int unsigned FCNT_W  = 5;

   localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(31);

   localparam logic [1:0] SEL_IDLE  = 2'b00;
   localparam logic [1:0] SEL_ILOAD = 2'b01;
   localparam logic [1:0] SEL_DLOAD = 2'b10;
   localparam logic [1:0] SEL_RUN   = 2'b11;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHIFT_I = 2'd1,
      SHIFT_D = 2'd2,
      RUN     = 2'd3
   } state_t;

endpackage

// File: rtl/frame_shifter.sv
// MSB-first frame shift register with a wrapping bit counter; latches each
// completed frame and flags it with a one-cycle frame_done.
module frame_shifter #(
   parameter int unsigned FRAME_W = 12
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       shift_en,
   input  logic                       clr,
   input  logic                       mosi,
   output logic                       last_bit_c,
   output logic [$clog2(FRAME_W)-1:0] bit_cnt,
   output logic                       frame_done,
   output logic [FRAME_W-1:0]         frame
);

   localparam int unsigned CNT_W = $clog2(FRAME_W);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_W - 1);

   logic [FRAME_W-1:0] sr_q;
   logic [CNT_W-1:0]   cnt_q;

   // last_bit_c must not depend on clr: the parent derives clr from it
   assign last_bit_c = shift_en && (cnt_q == LAST);
   assign bit_cnt    = cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q       <= '0;
         cnt_q      <= '0;
         frame_done <= 1'b0;
         frame      <= '0;
      end else begin
         frame_done <= last_bit_c;
         if (last_bit_c) begin
            frame <= {sr_q[FRAME_W-2:0], mosi};
         end
         if (clr) begin
            sr_q  <= '0;
            cnt_q <= '0;
         end else if (shift_en) begin
            sr_q  <= {sr_q[FRAME_W-2:0], mosi};
            cnt_q <= last_bit_c ? '0 : cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/spi_load_ctrl.sv
// Serial load controller: select decode, counted 12-bit frame commit to the
// icache/dcache write ports. Define SPI_READBACK_EN for MISO readback of the
// overwritten cache word.
module spi_load_ctrl
   import tp_pkg::*;
#(
   parameter int unsigned DATA_W = tp_pkg::DATA_W,
   parameter int unsigned ADDR_W = tp_pkg::ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            sel_in,
   input  logic                  mosi_in,
   input  logic [DATA_W-1:0]     rd_data_in,
   input  logic                  proc_done_in,
   output logic [ADDR_W-1:0]     wr_addr_out,
   output logic [DATA_W-1:0]     wr_data_out,
   output logic                  icache_wen_out,
   output logic                  dcache_wen_out,
   output logic                  run_out,
   output logic                  busy_out,
   output logic [FCNT_W-1:0]     frame_cnt_out,
   output logic                  frame_err_out,
   output logic                  miso_out
);

   localparam int unsigned FRAME_W = DATA_W + ADDR_W;
   localparam int unsigned CNT_W   = $clog2(FRAME_W);

   state_t state_q, state_d;

   logic               shift_c;
   logic               leave_c;
   logic               enter_shift_c;
   logic               enter_run_c;
   logic               clr_c;
   logic               abort_c;
   logic               last_bit_c;
   logic [CNT_W-1:0]   bit_cnt;
   logic               frame_done;
   logic [FRAME_W-1:0] frame;

   // proc_done_in is polled by the master through the pins; no state depends on it
   logic unused_ok;
   assign unused_ok = proc_done_in;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Every mode change passes through IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            case (sel_in)
               SEL_ILOAD: state_d = SHIFT_I;
               SEL_DLOAD: state_d = SHIFT_D;
               SEL_RUN:   state_d = RUN;
               default:   state_d = IDLE;
            endcase
         end
         SHIFT_I: if (sel_in != SEL_ILOAD) state_d = IDLE;
         SHIFT_D: if (sel_in != SEL_DLOAD) state_d = IDLE;
         RUN:     if (sel_in != SEL_RUN)   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign shift_c       = (state_q == SHIFT_I) || (state_q == SHIFT_D);
   assign leave_c       = shift_c && (state_d == IDLE);
   assign enter_shift_c = (state_q == IDLE) && ((state_d == SHIFT_I) || (state_d == SHIFT_D));
   assign enter_run_c   = (state_q == IDLE) && (state_d == RUN);
   // A bit sampled on the leaving cycle belongs to no frame unless it completes one
   assign clr_c         = enter_shift_c || (leave_c && !last_bit_c);
   assign abort_c       = leave_c && !last_bit_c && (bit_cnt != '0);

   frame_shifter #(
      .FRAME_W (FRAME_W)
   ) u_shifter (
      .clk        (clk),
      .rst        (rst),
      .shift_en   (shift_c),
      .clr        (clr_c),
      .mosi       (mosi_in),
      .last_bit_c (last_bit_c),
      .bit_cnt    (bit_cnt),
      .frame_done (frame_done),
      .frame      (frame)
   );

   assign wr_data_out = frame[FRAME_W-1:ADDR_W];
   assign wr_addr_out = frame[ADDR_W-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         icache_wen_out <= 1'b0;
         dcache_wen_out <= 1'b0;
         run_out        <= 1'b0;
         busy_out       <= 1'b0;
         frame_cnt_out  <= '0;
         frame_err_out  <= 1'b0;
      end else begin
         icache_wen_out <= last_bit_c && (state_q == SHIFT_I);
         dcache_wen_out <= last_bit_c && (state_q == SHIFT_D);
         run_out        <= (state_d == RUN);
         busy_out       <= (state_d == SHIFT_I) || (state_d == SHIFT_D) || last_bit_c;
         if (enter_shift_c) begin
            frame_cnt_out <= '0;
         end else if (last_bit_c && (frame_cnt_out != FCNT_MAX)) begin
            frame_cnt_out <= frame_cnt_out + FCNT_W'(1);
         end
         if (enter_run_c) begin
            frame_err_out <= 1'b0;
         end else if (abort_c) begin
            frame_err_out <= 1'b1;
         end
      end
   end

`ifdef SPI_READBACK_EN
   // Old word captured on the commit cycle, replayed MSB-first from the
   // cycle after capture; zeros shift in behind it
   logic [DATA_W-1:0] shadow_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q <= '0;
      end else if (enter_shift_c) begin
         shadow_q <= '0;
      end else if (frame_done) begin
         shadow_q <= rd_data_in;
      end else if (shift_c) begin
         shadow_q <= {shadow_q[DATA_W-2:0], 1'b0};
      end
   end

   assign miso_out = shadow_q[DATA_W-1];
`else
   logic unused_rd_ok;
   assign unused_rd_ok = ^rd_data_in;
   assign miso_out     = 1'b0;
`endif

endmodule

// File: tb/tb_spi_load_ctrl.sv
// Directed self-checking bench for spi_load_ctrl.
module tb_spi_load_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] sel_in;
   logic       mosi_in;
   logic [7:0] rd_data_in;
   logic       proc_done_in;
   logic [3:0] wr_addr_out;
   logic [7:0] wr_data_out;
   logic       icache_wen_out;
   logic       dcache_wen_out;
   logic       run_out;
   logic       busy_out;
   logic [4:0] frame_cnt_out;
   logic       frame_err_out;
   logic       miso_out;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int n_ip  = 0;
   int n_dp  = 0;
   int dp_cyc[$];

   logic [7:0] dcache [16];

   spi_load_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .sel_in         (sel_in),
      .mosi_in        (mosi_in),
      .rd_data_in     (rd_data_in),
      .proc_done_in   (proc_done_in),
      .wr_addr_out    (wr_addr_out),
      .wr_data_out    (wr_data_out),
      .icache_wen_out (icache_wen_out),
      .dcache_wen_out (dcache_wen_out),
      .run_out        (run_out),
      .busy_out       (busy_out),
      .frame_cnt_out  (frame_cnt_out),
      .frame_err_out  (frame_err_out),
      .miso_out       (miso_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) if (dcache_wen_out) dcache[wr_addr_out] <= wr_data_out;
   assign rd_data_in = dcache[wr_addr_out];

   always @(negedge clk) begin
      if (icache_wen_out) n_ip = n_ip + 1;
      if (dcache_wen_out) begin
         n_dp = n_dp + 1;
         dp_cyc.push_back(cyc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [11:0] f);
      for (int i = 11; i >= 0; i--) begin
         mosi_in = f[i];
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; sel_in = 2'b00; mosi_in = 1'b0; proc_done_in = 1'b0;
      for (int i = 0; i < 16; i++) dcache[i] = 8'h00;
      tick(); tick();
      rst = 1'b0;
      tick();
      n_cmp++; if ({icache_wen_out, dcache_wen_out, run_out, busy_out} !== 4'b0000) begin
         n_bad++; $display("FAIL reset_ctl: got %b want 0000", {icache_wen_out, dcache_wen_out, run_out, busy_out});
      end
      n_cmp++; if ({frame_cnt_out, frame_err_out, miso_out} !== 7'd0) begin
         n_bad++; $display("FAIL reset_stat: cnt=%0d err=%b miso=%b want 0", frame_cnt_out, frame_err_out, miso_out);
      end
      n_cmp++; if ({wr_addr_out, wr_data_out} !== 12'h000) begin
         n_bad++; $display("FAIL reset_wr: got %h want 000", {wr_addr_out, wr_data_out});
      end
   endtask

   task automatic test_iload();
      int ip0;
      ip0 = n_ip;
      sel_in = 2'b01;
      tick();
      n_cmp++; if (busy_out !== 1'b1) begin
         n_bad++; $display("FAIL iload_busy: got %b want 1", busy_out);
      end
      for (int i = 11; i >= 1; i--) begin
         mosi_in = (12'hA53 >> i) & 1; tick();
      end
      n_cmp++; if (icache_wen_out !== 1'b0) begin
         n_bad++; $display("FAIL iload_early: wen got %b want 0", icache_wen_out);
      end
      mosi_in = 1'b1; tick();
      n_cmp++; if ({icache_wen_out, dcache_wen_out} !== 2'b10) begin
         n_bad++; $display("FAIL iload_wen: got %b want 10", {icache_wen_out, dcache_wen_out});
      end
      n_cmp++; if ({wr_data_out, wr_addr_out, frame_cnt_out} !== {8'hA5, 4'h3, 5'd1}) begin
         n_bad++; $display("FAIL iload_frame: data=%h addr=%h cnt=%0d want a5 3 1", wr_data_out, wr_addr_out, frame_cnt_out);
      end
      sel_in = 2'b00; tick();
      n_cmp++; if ({icache_wen_out, frame_err_out, n_ip - ip0} !== {1'b0, 1'b0, 32'd1}) begin
         n_bad++; $display("FAIL iload_after: wen=%b err=%b pulses=%0d want 0 0 1", icache_wen_out, frame_err_out, n_ip - ip0);
      end
      tick();
      n_cmp++; if (busy_out !== 1'b0) begin
         n_bad++; $display("FAIL iload_idle_busy: got %b want 0", busy_out);
      end
   endtask

   task automatic test_back_to_back();
      logic [11:0] fr [3];
      int ip0, base;
      fr[0] = 12'h110; fr[1] = 12'h221; fr[2] = 12'h332;
      ip0 = n_ip; base = dp_cyc.size();
      sel_in = 2'b10;
      tick();
      for (int k = 0; k < 3; k++) begin
         send_frame(fr[k]);
         n_cmp++; if ({dcache_wen_out, wr_data_out, wr_addr_out, frame_cnt_out} !== {1'b1, fr[k], 5'(k + 1)}) begin
            n_bad++; $display("FAIL b2b_frame%0d: wen=%b data=%h addr=%h cnt=%0d want 1 %h %0d",
                              k, dcache_wen_out, wr_data_out, wr_addr_out, frame_cnt_out, fr[k], k + 1);
         end
      end
      sel_in = 2'b00; tick(); tick();
      n_cmp++; if (dp_cyc.size() - base !== 3) begin
         n_bad++; $display("FAIL b2b_count: got %0d want 3", dp_cyc.size() - base);
      end else begin
         n_cmp++; if ({dp_cyc[base+1] - dp_cyc[base], dp_cyc[base+2] - dp_cyc[base+1]} !== {32'd12, 32'd12}) begin
            n_bad++; $display("FAIL b2b_spacing: got %0d %0d want 12 12",
                              dp_cyc[base+1] - dp_cyc[base], dp_cyc[base+2] - dp_cyc[base+1]);
         end
      end
      n_cmp++; if ({n_ip - ip0, frame_err_out, dcache[1]} !== {32'd0, 1'b0, 8'h22}) begin
         n_bad++; $display("FAIL b2b_side: ipulses=%0d err=%b dcache1=%h want 0 0 22", n_ip - ip0, frame_err_out, dcache[1]);
      end
   endtask

   task automatic test_drop_on_last();
      sel_in = 2'b01;
      tick();
      for (int i = 11; i >= 1; i--) begin
         mosi_in = (12'h3C9 >> i) & 1; tick();
      end
      mosi_in = 1'b1; sel_in = 2'b00; tick();
      n_cmp++; if ({icache_wen_out, wr_data_out, wr_addr_out, frame_err_out, busy_out} !== {1'b1, 12'h3C9, 1'b0, 1'b1}) begin
         n_bad++; $display("FAIL drop_last: wen=%b data=%h addr=%h err=%b busy=%b want 1 3c 9 0 1",
                           icache_wen_out, wr_data_out, wr_addr_out, frame_err_out, busy_out);
      end
      tick();
      n_cmp++; if ({icache_wen_out, busy_out, frame_err_out} !== 3'b000) begin
         n_bad++; $display("FAIL drop_last_after: got %b want 000", {icache_wen_out, busy_out, frame_err_out});
      end
   endtask

   task automatic test_abort_then_run();
      int ip0, dp0;
      ip0 = n_ip; dp0 = n_dp;
      sel_in = 2'b01;
      tick();
      for (int i = 0; i < 7; i++) begin
         mosi_in = 1'(i); tick();
      end
      sel_in = 2'b00; tick(); tick();
      n_cmp++; if ({frame_err_out, busy_out, n_ip - ip0} !== {1'b1, 1'b0, 32'd0}) begin
         n_bad++; $display("FAIL abort: err=%b busy=%b pulses=%0d want 1 0 0", frame_err_out, busy_out, n_ip - ip0);
      end
      sel_in = 2'b11; tick();
      n_cmp++; if ({run_out, frame_err_out} !== 2'b10) begin
         n_bad++; $display("FAIL run_entry: run=%b err=%b want 1 0", run_out, frame_err_out);
      end
      for (int i = 0; i < 24; i++) begin
         mosi_in = ~mosi_in; tick();
      end
      n_cmp++; if ({run_out, busy_out, n_ip - ip0, n_dp - dp0} !== {1'b1, 1'b0, 32'd0, 32'd0}) begin
         n_bad++; $display("FAIL run_quiet: run=%b busy=%b ip=%0d dp=%0d want 1 0 0 0", run_out, busy_out, n_ip - ip0, n_dp - dp0);
      end
      sel_in = 2'b00; tick();
      n_cmp++; if (run_out !== 1'b0) begin
         n_bad++; $display("FAIL run_exit: got %b want 0", run_out);
      end
   endtask

   task automatic test_direct_run();
      sel_in = 2'b01; tick();
      mosi_in = 1'b1;
      sel_in = 2'b11; tick();
      n_cmp++; if ({run_out, busy_out, frame_err_out} !== 3'b000) begin
         n_bad++; $display("FAIL direct_idle: run=%b busy=%b err=%b want 000", run_out, busy_out, frame_err_out);
      end
      tick();
      n_cmp++; if (run_out !== 1'b1) begin
         n_bad++; $display("FAIL direct_run: got %b want 1", run_out);
      end
      sel_in = 2'b00; tick(); tick();
   endtask

   task automatic test_rst_mid_frame();
      int dp0;
      dp0 = n_dp;
      sel_in = 2'b10; tick();
      for (int i = 0; i < 5; i++) begin
         mosi_in = 1'b1; tick();
      end
      rst = 1'b1; tick();
      rst = 1'b0; sel_in = 2'b00; tick(); tick();
      n_cmp++; if ({icache_wen_out, dcache_wen_out, run_out, busy_out, frame_err_out, frame_cnt_out, wr_addr_out, wr_data_out, miso_out}
                   !== 23'd0) begin
         n_bad++; $display("FAIL rst_mid: err=%b cnt=%0d addr=%h data=%h busy=%b want all 0",
                           frame_err_out, frame_cnt_out, wr_addr_out, wr_data_out, busy_out);
      end
      n_cmp++; if (n_dp - dp0 !== 0) begin
         n_bad++; $display("FAIL rst_mid_pulse: got %0d want 0", n_dp - dp0);
      end
   endtask

   task automatic test_readback();
      logic [7:0] exp;
`ifdef SPI_READBACK_EN
      exp = 8'h5C;
`else
      exp = 8'h00;
`endif
      dcache[2] = 8'h5C;
      sel_in = 2'b10; tick();
      send_frame(12'hFF2);
      for (int j = 1; j <= 11; j++) begin
         mosi_in = 1'b0; tick();
         n_cmp++; if (miso_out !== ((j <= 8) ? exp[8-j] : 1'b0)) begin
            n_bad++; $display("FAIL readback_bit%0d: got %b want %b", j, miso_out, (j <= 8) ? exp[8-j] : 1'b0);
         end
      end
      sel_in = 2'b00; tick(); tick();
      n_cmp++; if (dcache[2] !== 8'hFF) begin
         n_bad++; $display("FAIL readback_write: got %h want ff", dcache[2]);
      end
   endtask

   initial begin
      test_reset();
      test_iload();
      test_back_to_back();
      test_drop_on_last();
      test_abort_then_run();
      test_direct_run();
      test_rst_mid_frame();
      test_readback();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
